mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency memory between the fetch stage (read-only) and the memory stage (load/store) of the 5-stage pipeline.
- Sequences each access through a req/ack handshake and returns read data to the correct requester.
- Drives fetch/memory stall enables that the pipeline control ORs into its existing stall logic.
- Data side has priority, since it belongs to the older instruction. A streak counter bounds fetch starvation.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width. Byte-enable width is DATA_W/8.
- MAX_D_STREAK, 4, consecutive data grants allowed while fetch is pending before fetch is forced. Legal range is 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  fetch request; held with i_addr stable until i_valid
- i_addr  in  ADDR_W  fetch address
- i_flush_en  in  1  branch flush; discards any outstanding fetch
- i_rdata  out  DATA_W  fetched instruction; valid only with i_valid
- i_valid  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_be stable until d_valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  store byte enables
- d_rdata  out  DATA_W  load data
- d_valid  out  1  one-cycle data completion pulse, for loads and stores
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  DATA_W/8  memory byte enables
- mem_ack  in  1  memory completion; sampled only while mem_req=1
- mem_rdata  in  DATA_W  read data, valid in the mem_ack cycle
- ma_out_stall_f_en  out  1  fetch stall
- ma_out_stall_m_en  out  1  memory-stage stall

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=IDLE; mem_req, mem_we, i_valid, d_valid=0.
  - mem_addr, mem_wdata, mem_be, i_rdata, d_rdata=0; streak=0; drop=0.
- Reset mid-access abandons the transaction. The memory is reset by the same rst_n.
- FSM states:
  - IDLE:
    - d_req and not (i_req and streak==MAX_D_STREAK): grant D; latch d_we/d_addr/d_wdata/d_be into the mem_* registers; go BUSY_D.
    - Else if i_req and not i_flush_en: grant I; latch i_addr, mem_we=0, mem_be=all ones; go BUSY_I.
    - Else stay in IDLE.
  - BUSY_I / BUSY_D: mem_req=1 with mem_* held constant. On mem_ack, register mem_rdata into i_rdata or d_rdata; mem_req=0 next cycle; go RESP_I or RESP_D.
  - RESP_I: i_valid=1 for exactly this cycle, unless drop=1; then go IDLE.
  - RESP_D: d_valid=1 for exactly this cycle; then go IDLE.
  - No grant is made in RESP states. This gives the requester one cycle to drop or advance its request.
- Minimum latency:
  - Request seen in cycle 0.
  - mem_req in cycle 1; with zero-wait ack, ack also in cycle 1.
  - valid in cycle 2; next grant possible in cycle 3.
- Streak counter:
  - On a D grant with i_req=1: streak increments, saturating at MAX_D_STREAK.
  - On an I grant, or a D grant with i_req=0: streak clears to 0.
- Flush:
  - i_flush_en in BUSY_I or RESP_I sets drop. The memory access still completes, but i_valid is suppressed and i_rdata is not updated.
  - drop clears on entering IDLE.
  - i_flush_en in IDLE blocks an I grant that cycle.
  - i_flush_en has no effect on D transactions.
- Stores: d_rdata keeps its previous value; d_valid still pulses.
- Stalls (combinational from state and requests):
  - stall_f = i_req and not i_valid.
  - stall_m = d_req and not d_valid.
- Simultaneous i_req and d_req in IDLE: D wins, except when streak==MAX_D_STREAK.
- mem_ack while mem_req=0 is ignored.

Decomposition:
- Shared package holds:
  - State encoding: IDLE=3'd0, BUSY_I=3'd1, BUSY_D=3'd2, RESP_I=3'd3, RESP_D=3'd4.
  - Requester IDs (REQ_I, REQ_D).
  - Default ADDR_W/DATA_W constants, shared with the pipeline top.
- Optional sub-module streak_counter: saturating up-counter with a clear input and an at-max output.
- FSM and datapath stay in mem_port_arbiter.

Test Plan:
- Single fetch, i_addr=0x100, mem_ack 2 cycles after mem_req -> mem_req high for cycles 1-3, mem_we=0, mem_be=4'hF; i_valid in cycle 4 with i_rdata=mem_rdata; stall_f high for cycles 0-3.
- Store, d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=4'b0011, zero-wait ack -> mem_we=1 and mem_* match the inputs in cycle 1; d_valid in cycle 2; d_rdata unchanged.
- i_req and d_req asserted together in cycle 0 -> D granted first; I granted in cycle 3; i_valid no earlier than cycle 5.
- d_req held continuously for 6 transactions with i_req high, MAX_D_STREAK=4 -> 4 D grants, then 1 I grant, then D resumes; streak returns to 0 after the I grant.
- i_flush_en pulsed during BUSY_I -> the memory access completes, no i_valid pulse, i_rdata keeps its old value; the next fetch after the flush completes normally.
- rst_n dropped while in BUSY_D -> mem_req, i_valid and d_valid go low immediately (asynchronously); after release, state is IDLE and the next d_req is granted in the following cycle.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared definitions for the fetch/data memory-port arbiter: FSM state
//   encoding, requester identifiers and the default bus widths used by the
//   pipeline top.
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  // Default widths, shared with the pipeline top.
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // Streak counter width; supports MAX_D_STREAK up to 15.
  localparam int STREAK_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

  // True while a memory access is outstanding (mem_req asserted).
  function automatic logic is_busy(input state_e s);
    return (s == BUSY_I) || (s == BUSY_D);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles the fetch port, data port, memory port and stall outputs of the
//   arbiter.
//   slave  : the arbiter's view (serves the pipeline, drives the memory).
//   master : the environment's view (pipeline stages plus memory).
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  localparam int BE_W = DATA_W / 8;

  // Fetch port
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_flush_en;
  logic [DATA_W-1:0] i_rdata;
  logic              i_valid;

  // Data port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_be;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;

  // Memory port
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  // Stall enables into the pipeline control
  logic              ma_out_stall_f_en;
  logic              ma_out_stall_m_en;

  modport slave (
    input  i_req, i_addr, i_flush_en,
    output i_rdata, i_valid,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_rdata, d_valid,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata,
    output ma_out_stall_f_en, ma_out_stall_m_en
  );

  modport master (
    output i_req, i_addr, i_flush_en,
    input  i_rdata, i_valid,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_rdata, d_valid,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata,
    input  ma_out_stall_f_en, ma_out_stall_m_en
  );

endinterface

// File: rtl/mem_port_arbiter_streak_counter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_streak_counter
//   Saturating up-counter of consecutive data grants made while fetch waits.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     inc        : count one more data grant (saturates at MAX_COUNT)
//     clr        : clear to zero (has priority over inc)
//     at_max     : count has reached MAX_COUNT; fetch must win next
// -----------------------------------------------------------------------------
module mem_port_arbiter_streak_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_COUNT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [STREAK_W-1:0] MAX_VAL = STREAK_W'(MAX_COUNT);

  logic [STREAK_W-1:0] count;

  // NOTE: state registers use non-blocking (<=) so every flop samples its
  // inputs from before the edge; blocking here would create order-dependent
  // races between always_ff blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX_VAL)) begin
      count <= count + STREAK_W'(1);
    end
  end

  assign at_max = (count == MAX_VAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port, variable-latency memory between the fetch stage
//   (read-only) and the memory stage (load/store). The data side wins ties
//   because it belongs to the older instruction; a streak counter forces a
//   fetch grant after MAX_D_STREAK consecutive data grants with fetch pending.
//   Each access runs IDLE -> BUSY_x (mem_req held until mem_ack) -> RESP_x
//   (one-cycle valid pulse) -> IDLE. No grant is made in RESP states so the
//   requester has a cycle to drop or advance its request.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     bus        : fetch, data and memory ports plus the two stall enables
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);

  localparam int BE_W = DATA_W / 8;

  state_e  state, state_next;
  logic    drop, drop_next;     // outstanding fetch was flushed
  logic    grant;
  req_id_e grant_id;
  logic    streak_inc, streak_clr, streak_at_max;

  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [BE_W-1:0]   mem_be_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      drop  <= 1'b0;
    end else begin
      state <= state_next;
      drop  <= drop_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and grant logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    drop_next  = drop;
    grant      = 1'b0;
    grant_id   = REQ_I;

    unique case (state)
      IDLE: begin
        if (bus.d_req && !(bus.i_req && streak_at_max)) begin
          grant      = 1'b1;
          grant_id   = REQ_D;
          state_next = BUSY_D;
        end else if (bus.i_req && !bus.i_flush_en) begin
          grant      = 1'b1;
          grant_id   = REQ_I;
          state_next = BUSY_I;
        end
      end
      BUSY_I:  if (bus.mem_ack) state_next = RESP_I;
      BUSY_D:  if (bus.mem_ack) state_next = RESP_D;
      RESP_I:  state_next = IDLE;
      RESP_D:  state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // A flush while a fetch is in flight lets the memory access finish but
    // suppresses its result. The flag lives only until the FSM is idle again.
    if (state_next == IDLE) begin
      drop_next = 1'b0;
    end else if (((state == BUSY_I) || (state == RESP_I)) && bus.i_flush_en) begin
      drop_next = 1'b1;
    end
  end

  // Streak counts data grants that made a waiting fetch wait longer; any
  // other grant restarts it.
  assign streak_inc = grant && (grant_id == REQ_D) && bus.i_req;
  assign streak_clr = grant && !streak_inc;

  mem_port_arbiter_streak_counter #(
    .MAX_COUNT (MAX_D_STREAK)
  ) u_streak (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (streak_inc),
    .clr    (streak_clr),
    .at_max (streak_at_max)
  );

  // ---------------------------------------------------------------------------
  // Datapath: memory command registers and response data
  // ---------------------------------------------------------------------------
  // NOTE: the command and read-data registers are reset too, so the memory
  // port and both rdata outputs are defined (zero) straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      if (grant) begin
        if (grant_id == REQ_D) begin
          mem_we_q    <= bus.d_we;
          mem_addr_q  <= bus.d_addr;
          mem_wdata_q <= bus.d_wdata;
          mem_be_q    <= bus.d_be;
        end else begin
          // Fetches are full-word reads; write data is irrelevant and held.
          mem_we_q    <= 1'b0;
          mem_addr_q  <= bus.i_addr;
          mem_be_q    <= '1;
        end
      end

      // A fetch flushed before or in its ack cycle must not update i_rdata.
      if ((state == BUSY_I) && bus.mem_ack && !drop && !bus.i_flush_en) begin
        i_rdata_q <= bus.mem_rdata;
      end

      // Stores leave the last load data in place.
      if ((state == BUSY_D) && bus.mem_ack && !mem_we_q) begin
        d_rdata_q <= bus.mem_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Handshake outputs decode the state directly, so an asynchronous reset
  // drops them immediately.
  assign bus.mem_req   = is_busy(state);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;

  assign bus.i_valid   = (state == RESP_I) && !drop;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_valid   = (state == RESP_D);
  assign bus.d_rdata   = d_rdata_q;

  assign bus.ma_out_stall_f_en = bus.i_req && !bus.i_valid;
  assign bus.ma_out_stall_m_en = bus.d_req && !bus.d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed self-checking bench for mem_port_arbiter. Inputs change 1 time
//   unit after the rising edge; outputs are sampled on the falling edge.
//   Cycle numbers in comments count from the cycle a request is first seen.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .MAX_D_STREAK (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle, just past the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Move to the sampling point of the current cycle.
  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    logic [9:0] exp_is_i;

    bus.i_req      = 1'b0;
    bus.i_addr     = '0;
    bus.i_flush_en = 1'b0;
    bus.d_req      = 1'b0;
    bus.d_we       = 1'b0;
    bus.d_addr     = '0;
    bus.d_wdata    = '0;
    bus.d_be       = '0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = '0;

    // ---------------- Reset state ----------------
    repeat (2) cyc();
    mid();
    check("rst_mem_req",  bus.mem_req, 0);
    check("rst_mem_we",   bus.mem_we, 0);
    check("rst_i_valid",  bus.i_valid, 0);
    check("rst_d_valid",  bus.d_valid, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_be",   bus.mem_be, 0);
    check("rst_i_rdata",  bus.i_rdata, 0);
    check("rst_d_rdata",  bus.d_rdata, 0);
    cyc();
    rst_n = 1'b1;

    // ---------------- Single fetch, ack 2 cycles after mem_req ----------------
    cyc();                                   // cycle 0
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h100;
    mid();
    check("f_c0_stall_f", bus.ma_out_stall_f_en, 1);
    check("f_c0_mem_req", bus.mem_req, 0);
    cyc();                                   // cycle 1
    mid();
    check("f_c1_mem_req",  bus.mem_req, 1);
    check("f_c1_mem_we",   bus.mem_we, 0);
    check("f_c1_mem_be",   bus.mem_be, 4'hF);
    check("f_c1_mem_addr", bus.mem_addr, 32'h100);
    check("f_c1_stall_f",  bus.ma_out_stall_f_en, 1);
    cyc();                                   // cycle 2
    mid();
    check("f_c2_mem_req", bus.mem_req, 1);
    check("f_c2_stall_f", bus.ma_out_stall_f_en, 1);
    cyc();                                   // cycle 3: ack
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    mid();
    check("f_c3_mem_req", bus.mem_req, 1);
    check("f_c3_i_valid", bus.i_valid, 0);
    check("f_c3_stall_f", bus.ma_out_stall_f_en, 1);
    cyc();                                   // cycle 4
    bus.mem_ack = 1'b0;
    mid();
    check("f_c4_i_valid", bus.i_valid, 1);
    check("f_c4_i_rdata", bus.i_rdata, 32'h1234_5678);
    check("f_c4_stall_f", bus.ma_out_stall_f_en, 0);
    check("f_c4_mem_req", bus.mem_req, 0);
    cyc();                                   // cycle 5
    bus.i_req = 1'b0;
    mid();
    check("f_c5_i_valid", bus.i_valid, 0);

    // ---------------- Load, zero-wait ----------------
    cyc();
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h3000;
    bus.d_be   = 4'hF;
    mid();
    check("ld_c0_stall_m", bus.ma_out_stall_m_en, 1);
    cyc();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFE_F00D;
    mid();
    check("ld_c1_mem_req",  bus.mem_req, 1);
    check("ld_c1_mem_addr", bus.mem_addr, 32'h3000);
    cyc();
    bus.mem_ack = 1'b0;
    mid();
    check("ld_c2_d_valid", bus.d_valid, 1);
    check("ld_c2_d_rdata", bus.d_rdata, 32'hCAFE_F00D);
    cyc();
    bus.d_req = 1'b0;

    // ---------------- Store, zero-wait ----------------
    cyc();                                   // cycle 0
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h2000;
    bus.d_wdata = 32'hDEAD_BEEF;
    bus.d_be    = 4'b0011;
    mid();
    check("st_c0_stall_m", bus.ma_out_stall_m_en, 1);
    cyc();                                   // cycle 1
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFF_0000;
    mid();
    check("st_c1_mem_req",   bus.mem_req, 1);
    check("st_c1_mem_we",    bus.mem_we, 1);
    check("st_c1_mem_addr",  bus.mem_addr, 32'h2000);
    check("st_c1_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    check("st_c1_mem_be",    bus.mem_be, 4'b0011);
    cyc();                                   // cycle 2
    bus.mem_ack = 1'b0;
    mid();
    check("st_c2_d_valid", bus.d_valid, 1);
    check("st_c2_d_rdata", bus.d_rdata, 32'hCAFE_F00D);
    check("st_c2_stall_m", bus.ma_out_stall_m_en, 0);
    check("st_c2_mem_req", bus.mem_req, 0);
    cyc();
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    mid();
    check("st_c3_d_valid", bus.d_valid, 0);

    // ---------------- Simultaneous i_req and d_req ----------------
    cyc();                                   // cycle 0
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h200;
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h4000;
    cyc();                                   // cycle 1: D in flight
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1111_1111;
    mid();
    check("sim_c1_mem_req",  bus.mem_req, 1);
    check("sim_c1_mem_addr", bus.mem_addr, 32'h4000);
    check("sim_c1_stall_f",  bus.ma_out_stall_f_en, 1);
    cyc();                                   // cycle 2
    bus.mem_ack = 1'b0;
    mid();
    check("sim_c2_d_valid", bus.d_valid, 1);
    check("sim_c2_d_rdata", bus.d_rdata, 32'h1111_1111);
    check("sim_c2_i_valid", bus.i_valid, 0);
    cyc();                                   // cycle 3: I granted from IDLE
    bus.d_req = 1'b0;
    mid();
    check("sim_c3_mem_req", bus.mem_req, 0);
    check("sim_c3_stall_f", bus.ma_out_stall_f_en, 1);
    cyc();                                   // cycle 4
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h2222_2222;
    mid();
    check("sim_c4_mem_req",  bus.mem_req, 1);
    check("sim_c4_mem_addr", bus.mem_addr, 32'h200);
    check("sim_c4_i_valid",  bus.i_valid, 0);
    cyc();                                   // cycle 5
    bus.mem_ack = 1'b0;
    mid();
    check("sim_c5_i_valid", bus.i_valid, 1);
    check("sim_c5_i_rdata", bus.i_rdata, 32'h2222_2222);
    cyc();
    bus.i_req = 1'b0;

    // ---------------- Streak limit (MAX_D_STREAK=4) ----------------
    // Both requests held, ack always high (ignored outside BUSY).
    // Expected order: D D D D I D D D D I.
    exp_is_i = 10'b10_0001_0000;
    cyc();
    bus.i_req     = 1'b1;
    bus.i_addr    = 32'h300;
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b0;
    bus.d_addr    = 32'h5000;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h7777_7777;
    for (int k = 0; k < 10; k++) begin
      cyc();                                 // BUSY
      mid();
      check($sformatf("stk%0d_mem_req", k), bus.mem_req, 1);
      check($sformatf("stk%0d_mem_addr", k), bus.mem_addr,
            exp_is_i[k] ? 64'h300 : 64'h5000);
      cyc();                                 // RESP
      mid();
      check($sformatf("stk%0d_i_valid", k), bus.i_valid, exp_is_i[k]);
      check($sformatf("stk%0d_d_valid", k), bus.d_valid, !exp_is_i[k]);
      cyc();                                 // IDLE of next transaction
    end
    bus.i_req   = 1'b0;
    bus.d_req   = 1'b0;
    bus.mem_ack = 1'b0;
    mid();
    check("stk_idle_mem_req", bus.mem_req, 0);

    // ---------------- Flush during BUSY_I ----------------
    cyc();                                   // cycle 0
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h400;
    cyc();                                   // cycle 1: BUSY_I, flush
    bus.i_flush_en = 1'b1;
    mid();
    check("fl_c1_mem_req", bus.mem_req, 1);
    cyc();                                   // cycle 2: ack still completes
    bus.i_flush_en = 1'b0;
    bus.mem_ack    = 1'b1;
    bus.mem_rdata  = 32'h4444_4444;
    mid();
    check("fl_c2_mem_req", bus.mem_req, 1);
    cyc();                                   // cycle 3: RESP_I suppressed
    bus.mem_ack = 1'b0;
    mid();
    check("fl_c3_i_valid", bus.i_valid, 0);
    check("fl_c3_i_rdata", bus.i_rdata, 32'h7777_7777);
    check("fl_c3_stall_f", bus.ma_out_stall_f_en, 1);
    check("fl_c3_mem_req", bus.mem_req, 0);
    cyc();                                   // cycle 4: refetch from new target
    bus.i_addr = 32'h500;
    cyc();                                   // cycle 5
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h5555_5555;
    mid();
    check("fl_c5_mem_req",  bus.mem_req, 1);
    check("fl_c5_mem_addr", bus.mem_addr, 32'h500);
    cyc();                                   // cycle 6
    bus.mem_ack = 1'b0;
    mid();
    check("fl_c6_i_valid", bus.i_valid, 1);
    check("fl_c6_i_rdata", bus.i_rdata, 32'h5555_5555);
    cyc();
    bus.i_req = 1'b0;

    // ---------------- Flush in IDLE blocks the fetch grant ----------------
    cyc();                                   // cycle 0
    bus.i_req      = 1'b1;
    bus.i_addr     = 32'h600;
    bus.i_flush_en = 1'b1;
    cyc();                                   // cycle 1: no grant was made
    bus.i_flush_en = 1'b0;
    mid();
    check("fi_c1_mem_req", bus.mem_req, 0);
    cyc();                                   // cycle 2
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h6666_6666;
    mid();
    check("fi_c2_mem_req",  bus.mem_req, 1);
    check("fi_c2_mem_addr", bus.mem_addr, 32'h600);
    cyc();                                   // cycle 3
    bus.mem_ack = 1'b0;
    mid();
    check("fi_c3_i_valid", bus.i_valid, 1);
    check("fi_c3_i_rdata", bus.i_rdata, 32'h6666_6666);
    cyc();
    bus.i_req = 1'b0;

    // ---------------- Reset during BUSY_D ----------------
    cyc();                                   // cycle 0
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h7000;
    cyc();                                   // cycle 1: BUSY_D
    mid();
    check("rb_busy_mem_req", bus.mem_req, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rb_async_mem_req",  bus.mem_req, 0);
    check("rb_async_i_valid",  bus.i_valid, 0);
    check("rb_async_d_valid",  bus.d_valid, 0);
    check("rb_async_mem_addr", bus.mem_addr, 0);
    check("rb_async_d_rdata",  bus.d_rdata, 0);
    cyc();                                   // release; IDLE sees d_req
    rst_n = 1'b1;
    mid();
    check("rb_rel_mem_req", bus.mem_req, 0);
    cyc();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h8888_8888;
    mid();
    check("rb_regrant_mem_req",  bus.mem_req, 1);
    check("rb_regrant_mem_addr", bus.mem_addr, 32'h7000);
    cyc();
    bus.mem_ack = 1'b0;
    mid();
    check("rb_d_valid", bus.d_valid, 1);
    check("rb_d_rdata", bus.d_rdata, 32'h8888_8888);
    cyc();
    bus.d_req = 1'b0;
    repeat (2) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
